// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access path: access sizes and the
// sub-word store sequencer states.
package mem_access_unit_pkg;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
   localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
   localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RMW_WR = 2'd1
   } state_t;

endpackage

// File: rtl/mem_access_unit_lane_extract.sv
// Byte/half lane selection with sign/zero extension, plus the bit mask of the
// selected lane(s) inside the word so the store merge can reuse the same decode.
module lane_extract
   import mem_access_unit_pkg::*;
#(
   parameter int BYTE_LITTLE = 1
) (
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_data,
   output logic [31:0] o_mask
);

   logic [4:0]  w_shamt;
   logic [31:0] w_shifted;
   logic        w_sign;

   // Big-endian lane n sits at bit 8*(3-n); for 2-bit n that is ~n.
   always_comb begin
      w_shamt = '0;
      case (i_size)
         MEM_SIZE_BYTE: w_shamt = (BYTE_LITTLE != 0) ? {i_off, 3'b000} : {~i_off, 3'b000};
         MEM_SIZE_HALF: w_shamt = (BYTE_LITTLE != 0) ? {i_off[1], 4'b0000} : {~i_off[1], 4'b0000};
         default:       w_shamt = '0;
      endcase
   end

   assign w_shifted = i_word >> w_shamt;

   always_comb begin
      o_data = i_word;
      o_mask = 32'hFFFF_FFFF;
      w_sign = 1'b0;
      case (i_size)
         MEM_SIZE_BYTE: begin
            w_sign = ~i_unsigned & w_shifted[7];
            o_data = {{24{w_sign}}, w_shifted[7:0]};
            o_mask = 32'h0000_00FF << w_shamt;
         end
         MEM_SIZE_HALF: begin
            w_sign = ~i_unsigned & w_shifted[15];
            o_data = {{16{w_sign}}, w_shifted[15:0]};
            o_mask = 32'h0000_FFFF << w_shamt;
         end
         default: begin
            o_data = i_word;
            o_mask = 32'hFFFF_FFFF;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage front end for a word-only data RAM: sub-word loads, sub-word stores
// as a two-cycle read-modify-write, and misaligned-access suppression.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int BYTE_LITTLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata_out,
   output logic        stall,
   output logic        addr_err,
   output logic        dm_rd,
   output logic        dm_wr,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_merge;
   logic [29:0] r_waddr;

   logic        w_req;
   logic        w_sub;
   logic        w_mis;
   logic        w_capture;
   logic [31:0] w_ext;
   logic [31:0] w_mask;
   logic [31:0] w_fill;
   logic [31:0] w_merged;

   assign w_req = mem_rd | mem_wr;
   assign w_sub = (mem_size == MEM_SIZE_BYTE) || (mem_size == MEM_SIZE_HALF);
   assign w_mis = w_req && (((mem_size == MEM_SIZE_HALF) && addr[0]) ||
                            (mem_size[1] && (addr[1:0] != 2'b00)));

   lane_extract #(
      .BYTE_LITTLE (BYTE_LITTLE)
   ) u_lane (
      .i_word     (dm_rdata),
      .i_off      (addr[1:0]),
      .i_size     (mem_size),
      .i_unsigned (mem_unsigned),
      .o_data     (w_ext),
      .o_mask     (w_mask)
   );

   // Replicating the store data lets the lane mask place it for either byte order.
   assign w_fill   = (mem_size == MEM_SIZE_BYTE) ? {4{wdata[7:0]}} : {2{wdata[15:0]}};
   assign w_merged = (dm_rdata & ~w_mask) | (w_fill & w_mask);

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      stall     = 1'b0;
      addr_err  = 1'b0;
      dm_rd     = 1'b0;
      dm_wr     = 1'b0;
      dm_addr   = {addr[31:2], 2'b00};
      dm_wdata  = wdata;
      rdata_out = '0;
      if (!reset) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               addr_err = w_mis;
               if (!w_mis) begin
                  if (mem_wr) begin
                     if (w_sub) begin
                        dm_rd     = 1'b1;
                        stall     = 1'b1;
                        w_capture = 1'b1;
                        w_next    = ST_RMW_WR;
                     end else begin
                        dm_wr = 1'b1;
                     end
                  end else if (mem_rd) begin
                     dm_rd     = 1'b1;
                     rdata_out = w_ext;
                  end
               end
            end
            ST_RMW_WR: begin
               // The stalled pipeline still presents the same store; ignore it.
               dm_wr    = 1'b1;
               dm_addr  = {r_waddr, 2'b00};
               dm_wdata = r_merge;
               w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_merge <= '0;
         r_waddr <= '0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_merge <= w_merged;
            r_waddr <= addr[31:2];
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 256x32 async-read RAM model.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        mem_rd;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata_out;
   logic        stall;
   logic        addr_err;
   logic        dm_rd;
   logic        dm_wr;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;

   logic [31:0] ram [256];
   int checks;
   int failures;

   mem_access_unit #(.BYTE_LITTLE(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .addr         (addr),
      .wdata        (wdata),
      .rdata_out    (rdata_out),
      .stall        (stall),
      .addr_err     (addr_err),
      .dm_rd        (dm_rd),
      .dm_wr        (dm_wr),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_rdata = ram[dm_addr[9:2]];
   always @(posedge clk) if (dm_wr) ram[dm_addr[9:2]] <= dm_wdata;

   // Apply a request mid-cycle and let the combinational outputs settle.
   task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      mem_rd = rd; mem_wr = wr; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
      #2;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checks++; if (dm_rd !== 1'b0) begin failures++; $display("FAIL reset_dm_rd got=%b exp=0", dm_rd); end
      checks++; if (rdata_out !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", rdata_out); end
      drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAB);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (dm_wr !== 1'b0 || dm_rd !== 1'b0) begin failures++; $display("FAIL reset_dm got=%b%b exp=00", dm_rd, dm_wr); end
      drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'hBEEF);
      checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_word();
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
      checks++; if (dm_wr !== 1'b1 || dm_rd !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL sw_ctrl got wr=%b rd=%b stall=%b exp 1 0 0", dm_wr, dm_rd, stall); end
      checks++; if (dm_wdata !== 32'h12345678 || dm_addr !== 32'h10) begin failures++; $display("FAIL sw_data got=%h@%h exp=12345678@00000010", dm_wdata, dm_addr); end
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checks++; if (rdata_out !== 32'h12345678 || dm_rd !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL lw got=%h rd=%b stall=%b exp=12345678 1 0", rdata_out, dm_rd, stall); end
   endtask

   task automatic test_sb();
      drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAB);
      checks++; if (stall !== 1'b1 || dm_rd !== 1'b1 || dm_wr !== 1'b0) begin failures++; $display("FAIL sb_read got stall=%b rd=%b wr=%b exp 1 1 0", stall, dm_rd, dm_wr); end
      #5;
      @(negedge clk); #2;
      checks++; if (stall !== 1'b0 || dm_wr !== 1'b1 || dm_rd !== 1'b0) begin failures++; $display("FAIL sb_write got stall=%b wr=%b rd=%b exp 0 1 0", stall, dm_wr, dm_rd); end
      checks++; if (dm_wdata !== 32'h1234AB78 || dm_addr !== 32'h10) begin failures++; $display("FAIL sb_merge got=%h@%h exp=1234AB78@00000010", dm_wdata, dm_addr); end
      idle();
      checks++; if (stall !== 1'b0 || dm_wr !== 1'b0) begin failures++; $display("FAIL sb_done got stall=%b wr=%b exp 0 0", stall, dm_wr); end
      checks++; if (ram[4] !== 32'h1234AB78) begin failures++; $display("FAIL sb_ram got=%h exp=1234AB78", ram[4]); end
   endtask

   task automatic test_loads();
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      checks++; if (rdata_out !== 32'hFFFFFFAB) begin failures++; $display("FAIL lb got=%h exp=FFFFFFAB", rdata_out); end
      drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      checks++; if (rdata_out !== 32'h000000AB) begin failures++; $display("FAIL lbu got=%h exp=000000AB", rdata_out); end
      drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
      checks++; if (rdata_out !== 32'h00001234) begin failures++; $display("FAIL lh_hi got=%h exp=00001234", rdata_out); end
      drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
      checks++; if (rdata_out !== 32'hFFFFAB78) begin failures++; $display("FAIL lh_lo got=%h exp=FFFFAB78", rdata_out); end
      drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
      checks++; if (rdata_out !== 32'h0000AB78) begin failures++; $display("FAIL lhu got=%h exp=0000AB78", rdata_out); end
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      checks++; if (rdata_out !== 32'h00000012) begin failures++; $display("FAIL lb3 got=%h exp=00000012", rdata_out); end
   endtask

   task automatic test_misaligned();
      drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'hBEEF);
      checks++; if (addr_err !== 1'b1 || dm_wr !== 1'b0 || dm_rd !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL sh_mis got err=%b wr=%b rd=%b stall=%b exp 1 0 0 0", addr_err, dm_wr, dm_rd, stall); end
      idle();
      checks++; if (ram[4] !== 32'h1234AB78 || dm_wr !== 1'b0) begin failures++; $display("FAIL sh_mis_ram got=%h wr=%b exp=1234AB78 0", ram[4], dm_wr); end
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
      checks++; if (addr_err !== 1'b1 || rdata_out !== 32'h0 || dm_rd !== 1'b0) begin failures++; $display("FAIL lw_mis got err=%b data=%h rd=%b exp 1 00000000 0", addr_err, rdata_out, dm_rd); end
      drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h11, 32'h0);
      checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL rsv_mis got=%b exp=1", addr_err); end
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL lb_odd_err got=%b exp=0", addr_err); end
   endtask

   task automatic test_sh();
      drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sh_stall got=%b exp=1", stall); end
      @(negedge clk); #2;
      checks++; if (dm_wr !== 1'b1 || dm_wdata !== 32'hBEEFAB78) begin failures++; $display("FAIL sh_merge got wr=%b data=%h exp 1 BEEFAB78", dm_wr, dm_wdata); end
      idle();
   endtask

   task automatic test_reset_rmw();
      drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h55);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rr_stall got=%b exp=1", stall); end
      @(negedge clk); reset = 1'b0; #2;
      checks++; if (dm_wr !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rr_gate got wr=%b stall=%b exp 0 0", dm_wr, stall); end
      @(negedge clk); reset = 1'b1;
      mem_rd = 1'b0; mem_wr = 1'b0; #2;
      checks++; if (ram[4] !== 32'hBEEFAB78 || dm_wr !== 1'b0) begin failures++; $display("FAIL rr_ram got=%h wr=%b exp=BEEFAB78 0", ram[4], dm_wr); end
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checks++; if (rdata_out !== 32'hBEEFAB78 || stall !== 1'b0) begin failures++; $display("FAIL rr_idle got=%h stall=%b exp=BEEFAB78 0", rdata_out, stall); end
   endtask

   task automatic test_both();
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
      checks++; if (dm_wr !== 1'b1 || rdata_out !== 32'h0 || stall !== 1'b0) begin failures++; $display("FAIL both got wr=%b data=%h stall=%b exp 1 00000000 0", dm_wr, rdata_out, stall); end
      idle();
      checks++; if (ram[8] !== 32'hCAFEF00D) begin failures++; $display("FAIL both_ram got=%h exp=CAFEF00D", ram[8]); end
      checks++; if (dm_rd !== 1'b0 || dm_wr !== 1'b0 || rdata_out !== 32'h0) begin failures++; $display("FAIL none got rd=%b wr=%b data=%h exp 0 0 00000000", dm_rd, dm_wr, rdata_out); end
   endtask

   task automatic test_back_to_back();
      drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h77);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall got=%b exp=1", stall); end
      @(negedge clk); #2;
      checks++; if (dm_wdata !== 32'hCAFE770D || dm_addr !== 32'h20) begin failures++; $display("FAIL b2b_merge got=%h@%h exp=CAFE770D@00000020", dm_wdata, dm_addr); end
      drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
      checks++; if (rdata_out !== 32'h00000077 || stall !== 1'b0) begin failures++; $display("FAIL b2b_lb got=%h stall=%b exp=00000077 0", rdata_out, stall); end
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checks++; if (rdata_out !== 32'hCAFE770D) begin failures++; $display("FAIL b2b_lw got=%h exp=CAFE770D", rdata_out); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      reset = 1'b0;
      mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
      addr = 32'h0; wdata = 32'h0;
      repeat (2) @(posedge clk);
      test_reset();
      test_word();
      test_sb();
      test_loads();
      test_misaligned();
      test_sh();
      test_reset_rmw();
      test_both();
      test_back_to_back();
      idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
